// File: rtl/demux_pkg.sv
// Shared definitions for the packet demultiplexer: the framing state encoding,
// the output port indices, the packet counter width and the port-selection rule.
package demux_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } demux_state_e;

    localparam logic PORT0     = 1'b0;
    localparam logic PORT1     = 1'b1;
    localparam int   CNT_WIDTH = 8;

    // Outside a packet the select input chooses the port; inside one the lock holds it.
    function automatic logic target_port(input demux_state_e state,
                                         input logic         lock,
                                         input logic         sel);
        logic port;
        if (state == IDLE) begin
            port = sel;
        end else begin
            port = lock;
        end
        return port;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready handshake. A load while the held
// beat is being drained replaces it in the same cycle, so a stream can pass at
// one beat per cycle without bubbles.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic             can_load
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             last_r;

    // Capture a new beat, or release the held beat once the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
            last_r  <= load_last;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end
    end

    assign data     = data_r;
    assign valid    = valid_r;
    assign last     = last_r;
    assign can_load = !valid_r || ready;

endmodule

// File: rtl/demultiplexer.sv
// Packet demultiplexer: routes each packet from the input stream to one of two
// output ports. The destination is chosen on the first beat and locked for the
// rest of the packet. Each port has a one-entry output register and a count of
// packets fully delivered on it.
module demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic                 a_valid,
    input  logic                 a_last,
    output logic                 a_ready,
    input  logic                 s,
    output logic [WIDTH-1:0]     w0,
    output logic                 w0_valid,
    output logic                 w0_last,
    input  logic                 w0_ready,
    output logic [WIDTH-1:0]     w1,
    output logic                 w1_valid,
    output logic                 w1_last,
    input  logic                 w1_ready,
    output logic [CNT_WIDTH-1:0] pkt_cnt0,
    output logic [CNT_WIDTH-1:0] pkt_cnt1
);

    demux_state_e         state_r;
    logic                 lock_r;
    logic                 target_s;
    logic                 accept_s;
    logic                 load0_s;
    logic                 load1_s;
    logic                 can_load0_s;
    logic                 can_load1_s;
    logic [CNT_WIDTH-1:0] cnt0_r;
    logic [CNT_WIDTH-1:0] cnt1_r;

    // Pick the target port and accept only when that port's slot can take a beat
    always_comb begin
        target_s = target_port(state_r, lock_r, s);
        a_ready  = 1'b0;
        if (rst) begin
            a_ready = 1'b0;
        end else if (target_s == PORT1) begin
            a_ready = can_load1_s;
        end else begin
            a_ready = can_load0_s;
        end
        accept_s = a_valid && a_ready;
        load0_s  = accept_s && (target_s == PORT0);
        load1_s  = accept_s && (target_s == PORT1);
    end

    // Packet framing: open on a non-final first beat, close on the final beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            lock_r  <= PORT0;
        end else if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (!a_last) begin
                        state_r <= PKT;
                        lock_r  <= s;
                    end
                end
                PKT: begin
                    if (a_last) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    lock_r  <= PORT0;
                end
            endcase
        end
    end

    // Count completed packets per port as their final beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_r <= {CNT_WIDTH{1'b0}};
            cnt1_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w0_valid && w0_ready && w0_last) begin
                cnt0_r <= cnt0_r + 8'd1;
            end
            if (w1_valid && w1_ready && w1_last) begin
                cnt1_r <= cnt1_r + 8'd1;
            end
        end
    end

    assign pkt_cnt0 = cnt0_r;
    assign pkt_cnt1 = cnt1_r;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0_s),
        .load_data (a),
        .load_last (a_last),
        .ready     (w0_ready),
        .data      (w0),
        .valid     (w0_valid),
        .last      (w0_last),
        .can_load  (can_load0_s)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1_s),
        .load_data (a),
        .load_last (a_last),
        .ready     (w1_ready),
        .data      (w1),
        .valid     (w1_valid),
        .last      (w1_last),
        .can_load  (can_load1_s)
    );

endmodule

// File: tb/tb_demultiplexer.sv
// Self-checking bench for the packet demultiplexer: a behavioural model of
// per-port pending beats and packet counts, checked on every falling edge,
// plus directed scenarios with hand-computed delivery logs and counter values.
module tb_demultiplexer;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] a        = 8'h00;
    logic       a_valid  = 1'b0;
    logic       a_last   = 1'b0;
    logic       s        = 1'b0;
    logic       w0_ready = 1'b0;
    logic       w1_ready = 1'b0;
    logic       a_ready;
    logic [7:0] w0, w1;
    logic       w0_valid, w1_valid, w0_last, w1_last;
    logic [7:0] pkt_cnt0, pkt_cnt1;

    int checks = 0;
    int errors = 0;

    // delivered beats seen on each port, {last, data}
    logic [8:0] log0[$];
    logic [8:0] log1[$];

    // model: pending beat per port, packet counts, open packet port (-1 = none)
    logic       mv[2];
    logic [7:0] md[2];
    logic       ml[2];
    logic [7:0] mcnt[2];
    int         mopen;

    demultiplexer #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .a_valid  (a_valid),
        .a_last   (a_last),
        .a_ready  (a_ready),
        .s        (s),
        .w0       (w0),
        .w0_valid (w0_valid),
        .w0_last  (w0_last),
        .w0_ready (w0_ready),
        .w1       (w1),
        .w1_valid (w1_valid),
        .w1_last  (w1_last),
        .w1_ready (w1_ready),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    // free-running clock
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model update: each rising edge drains ready ports and stores an accepted beat
    always @(posedge clk) begin
        int   p;
        logic acc;
        logic rdy[2];
        if (rst) begin
            for (int q = 0; q < 2; q++) begin
                mv[q]   <= 1'b0;
                md[q]   <= 8'h00;
                ml[q]   <= 1'b0;
                mcnt[q] <= 8'h00;
            end
            mopen <= -1;
        end else begin
            rdy[0] = w0_ready;
            rdy[1] = w1_ready;
            p   = (mopen < 0) ? int'(s) : mopen;
            acc = a_valid && (!mv[p] || rdy[p]);
            for (int q = 0; q < 2; q++) begin
                if (mv[q] && rdy[q]) begin
                    mv[q] <= 1'b0;
                    if (ml[q]) mcnt[q] <= mcnt[q] + 8'd1;
                end
            end
            if (acc) begin
                mv[p] <= 1'b1;
                md[p] <= a;
                ml[p] <= a_last;
                if (mopen < 0) begin
                    if (!a_last) mopen <= int'(s);
                end else if (a_last) begin
                    mopen <= -1;
                end
            end
        end
    end

    // compare DUT against the model every falling edge and log deliveries
    always @(negedge clk) begin
        int   p;
        logic ear;
        if (rst) begin
            chk("rst_a_ready", a_ready, 0);
            chk("rst_w0_valid", w0_valid, 0);
            chk("rst_w1_valid", w1_valid, 0);
            chk("rst_w0_last", w0_last, 0);
            chk("rst_w1_last", w1_last, 0);
            chk("rst_w0", w0, 0);
            chk("rst_w1", w1, 0);
            chk("rst_cnt0", pkt_cnt0, 0);
            chk("rst_cnt1", pkt_cnt1, 0);
        end else begin
            p   = (mopen < 0) ? int'(s) : mopen;
            ear = !mv[p] || ((p == 0) ? w0_ready : w1_ready);
            chk("a_ready", a_ready, ear);
            chk("w0_valid", w0_valid, mv[0]);
            chk("w1_valid", w1_valid, mv[1]);
            if (mv[0]) begin
                chk("w0", w0, md[0]);
                chk("w0_last", w0_last, ml[0]);
            end
            if (mv[1]) begin
                chk("w1", w1, md[1]);
                chk("w1_last", w1_last, ml[1]);
            end
            chk("pkt_cnt0", pkt_cnt0, mcnt[0]);
            chk("pkt_cnt1", pkt_cnt1, mcnt[1]);
            if (w0_valid && w0_ready) log0.push_back({w0_last, w0});
            if (w1_valid && w1_ready) log1.push_back({w1_last, w1});
        end
    end

    task automatic idle(input int n);
        a_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // offer one beat and hold it until accepted, bounded
    task automatic send(input logic [7:0] d, input logic l, input logic sel);
        logic done;
        done    = 1'b0;
        a       = d;
        a_last  = l;
        s       = sel;
        a_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = a_ready;
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout beat=%0h accepted=0 required=1", d);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        a_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog finished=0 required=1");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("reset_cnt0", pkt_cnt0, 0);
        chk("reset_w1_valid", w1_valid, 0);

        // single-beat packet to port 1
        w0_ready = 1'b1;
        w1_ready = 1'b1;
        send(8'hA5, 1'b1, 1'b1);
        chk("single_w1", w1, 8'hA5);
        chk("single_w1_valid", w1_valid, 1);
        chk("single_w1_last", w1_last, 1);
        chk("single_w0_valid", w0_valid, 0);
        idle(1);
        chk("single_cnt1", pkt_cnt1, 1);
        chk("single_w1_drained", w1_valid, 0);

        // port lock: select changes mid-packet are ignored
        log0.delete();
        log1.delete();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b1, 1'b1);
        idle(2);
        chk("lock_n0", log0.size(), 3);
        chk("lock_n1", log1.size(), 0);
        if (log0.size() == 3) begin
            chk("lock_b0", log0[0], 9'h011);
            chk("lock_b1", log0[1], 9'h022);
            chk("lock_b2", log0[2], 9'h133);
        end
        chk("lock_cnt0", pkt_cnt0, 1);

        // backpressure: port 0 stalled for five cycles
        log0.delete();
        w0_ready = 1'b0;
        send(8'h40, 1'b0, 1'b0);
        a       = 8'h41;
        a_last  = 1'b0;
        s       = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_w0_hold", w0, 8'h40);
            chk("bp_w0_valid", w0_valid, 1);
            @(posedge clk);
            #1;
        end
        w0_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(8'h40 + 8'(i), (i == 5), 1'b0);
        idle(2);
        chk("bp_n", log0.size(), 6);
        if (log0.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("bp_beat", log0[i], {(i == 5), 8'h40 + 8'(i)});
        end
        chk("bp_cnt0", pkt_cnt0, 2);

        // independent drain: port 1 stalled while port 0 streams
        log1.delete();
        w1_ready = 1'b0;
        send(8'h77, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a       = 8'h50 + 8'(i);
            a_last  = (i == 3);
            s       = 1'b0;
            a_valid = 1'b1;
            @(negedge clk);
            chk("drain_a_ready", a_ready, 1);
            chk("drain_w1_hold", w1, 8'h77);
            chk("drain_w1_valid", w1_valid, 1);
            @(posedge clk);
            #1;
        end
        a_valid  = 1'b0;
        w1_ready = 1'b1;
        idle(2);
        chk("drain_cnt0", pkt_cnt0, 3);
        chk("drain_cnt1", pkt_cnt1, 2);
        chk("drain_n1", log1.size(), 1);

        // counter wrap on port 0
        do_reset();
        for (int i = 0; i < 255; i++) send(8'(i), 1'b1, 1'b0);
        idle(2);
        chk("wrap_255", pkt_cnt0, 255);
        send(8'hFF, 1'b1, 1'b0);
        idle(2);
        chk("wrap_0", pkt_cnt0, 0);

        // reset in the middle of a packet locked to port 1
        send(8'h90, 1'b0, 1'b1);
        send(8'h91, 1'b0, 1'b1);
        rst     = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_w1_valid", w1_valid, 0);
        chk("mid_rst_w1", w1, 0);
        chk("mid_rst_cnt0", pkt_cnt0, 0);
        chk("mid_rst_a_ready", a_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        log0.delete();
        log1.delete();
        send(8'h92, 1'b1, 1'b0);
        idle(2);
        chk("mid_rst_n0", log0.size(), 1);
        if (log0.size() == 1) chk("mid_rst_beat", log0[0], 9'h192);
        chk("mid_rst_n1", log1.size(), 0);
        chk("mid_rst_cnt0_after", pkt_cnt0, 1);
        chk("mid_rst_cnt1_after", pkt_cnt1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
